// File: rtl/alu_op_sequencer.sv
// Per-instruction controller for the 6502 ALU: drives one ALU pass (two for decimal
// ADC/SBC), samples the inverted result nets and returns the byte plus N/Z/C/V.
module alu_op_sequencer #(
    parameter bit DEC_EN = 1'b1
) (
    input  logic       clk_2,
    input  logic       res_n,
    input  logic       start,
    input  logic [3:0] op,
    input  logic [7:0] opnd_a,
    input  logic [7:0] opnd_b,
    input  logic       c_in,
    input  logic       d_in,
    input  logic       v_in,
    input  logic [7:0] result_n,
    input  logic       alu_cout_n,
    input  logic       overflow_n,
    input  logic       half_carry,
    output logic       sums,
    output logic       ands,
    output logic       eors,
    output logic       ors,
    output logic       srs,
    output logic       alu_cin_n,
    output logic       daa_n,
    output logic       dsa_n,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       n_out,
    output logic       z_out,
    output logic       c_out,
    output logic       v_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_ADJ  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADC = 4'h0;
    localparam logic [3:0] OP_SBC = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_ORA = 4'h3;
    localparam logic [3:0] OP_EOR = 4'h4;
    localparam logic [3:0] OP_CMP = 4'h5;
    localparam logic [3:0] OP_ASL = 4'h6;
    localparam logic [3:0] OP_LSR = 4'h7;
    localparam logic [3:0] OP_ROL = 4'h8;
    localparam logic [3:0] OP_ROR = 4'h9;
    localparam logic [3:0] OP_INC = 4'hA;
    localparam logic [3:0] OP_DEC = 4'hB;

    state_t     state_q, state_d;
    logic [3:0] op_q;
    logic [7:0] a_q, b_q;
    logic       c_q, v_q, dec_q;
    logic       dec_d;

    // First-pass ALU samples, needed by the decimal correction pass and its flags.
    logic [7:0] r_q;
    logic       alu_c_q, alu_v_q, hc_q;

    logic [7:0] result_q, result_d;
    logic       n_q, z_q, c_out_q, v_out_q;
    logic       n_d, z_d, c_out_d, v_out_d;

    logic       accept;
    logic       write_out;
    logic [7:0] alu_r;
    logic       alu_c, alu_v;
    logic       carry_sel, ovf_sel;
    logic [7:0] flag_src;
    logic [7:0] adj_b;
    logic       adj_lo, adj_hi;

    assign alu_r = ~result_n;
    assign alu_c = ~alu_cout_n;
    assign alu_v = ~overflow_n;

    assign dec_d = d_in & DEC_EN & ((op == OP_ADC) | (op == OP_SBC));

    // Decimal correction constants: +06/+60 after add, -06/-60 (two's complement) after subtract.
    always_comb begin
        adj_lo = 1'b0;
        adj_hi = 1'b0;
        adj_b  = 8'h00;
        if (op_q == OP_SBC) begin
            adj_lo = ~hc_q;
            adj_hi = ~alu_c_q;
            adj_b  = (adj_lo ? 8'hFA : 8'h00) + (adj_hi ? 8'hA0 : 8'h00);
        end else begin
            adj_lo = hc_q;
            adj_hi = alu_c_q;
            adj_b  = {(adj_hi ? 4'h6 : 4'h0), (adj_lo ? 4'h6 : 4'h0)};
        end
    end

    // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        sums      = 1'b0;
        ands      = 1'b0;
        eors      = 1'b0;
        ors       = 1'b0;
        srs       = 1'b0;
        alu_cin_n = 1'b1;
        daa_n     = 1'b1;
        dsa_n     = 1'b1;
        alu_a     = 8'h00;
        alu_b     = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_EXEC;
                    accept  = 1'b1;
                end
            end
            S_EXEC: begin
                busy    = 1'b1;
                state_d = dec_q ? S_ADJ : S_DONE;
                alu_a   = a_q;
                case (op_q)
                    OP_ADC: begin
                        sums      = 1'b1;
                        alu_b     = b_q;
                        alu_cin_n = ~c_q;
                        daa_n     = ~dec_q;
                    end
                    OP_SBC: begin
                        sums      = 1'b1;
                        alu_b     = ~b_q;
                        alu_cin_n = ~c_q;
                        dsa_n     = ~dec_q;
                    end
                    OP_AND: begin
                        ands  = 1'b1;
                        alu_b = b_q;
                    end
                    OP_ORA: begin
                        ors   = 1'b1;
                        alu_b = b_q;
                    end
                    OP_EOR: begin
                        eors  = 1'b1;
                        alu_b = b_q;
                    end
                    OP_CMP: begin
                        sums      = 1'b1;
                        alu_b     = ~b_q;
                        alu_cin_n = 1'b0;
                    end
                    OP_ASL, OP_ROL: begin
                        sums      = 1'b1;
                        alu_b     = a_q;
                        alu_cin_n = (op_q == OP_ROL) ? ~c_q : 1'b1;
                    end
                    OP_LSR, OP_ROR: begin
                        srs   = 1'b1;
                        alu_b = a_q;
                    end
                    OP_INC: begin
                        sums      = 1'b1;
                        alu_b     = 8'h00;
                        alu_cin_n = 1'b0;
                    end
                    OP_DEC: begin
                        sums      = 1'b1;
                        alu_b     = 8'hFF;
                        alu_cin_n = 1'b1;
                    end
                    default: begin
                        alu_b = 8'h00;
                    end
                endcase
            end
            S_ADJ: begin
                busy    = 1'b1;
                state_d = S_DONE;
                sums    = 1'b1;
                alu_a   = r_q;
                alu_b   = adj_b;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d = S_EXEC;
                    accept  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Leaving ADJ, carry and overflow come from the first pass, not the correction add.
    assign carry_sel = (state_q == S_ADJ) ? alu_c_q : alu_c;
    assign ovf_sel   = (state_q == S_ADJ) ? alu_v_q : alu_v;
    assign write_out = busy && (state_d == S_DONE);

    always_comb begin
        result_d = alu_r;
        c_out_d  = c_q;
        v_out_d  = v_q;
        case (op_q)
            OP_ADC, OP_SBC: begin
                c_out_d = carry_sel;
                v_out_d = ovf_sel;
            end
            OP_ASL, OP_ROL: c_out_d = carry_sel;
            OP_ROR: begin
                result_d = {c_q, alu_r[6:0]};
                c_out_d  = a_q[0];
            end
            OP_LSR: begin
                result_d = {1'b0, alu_r[6:0]};
                c_out_d  = a_q[0];
            end
            OP_CMP: begin
                result_d = a_q;
                c_out_d  = carry_sel;
            end
            OP_AND, OP_ORA, OP_EOR, OP_INC, OP_DEC: result_d = alu_r;
            default: result_d = a_q;
        endcase
        // Compare reports N/Z of the difference while handing back A unchanged.
        flag_src = (op_q == OP_CMP) ? alu_r : result_d;
        n_d      = flag_src[7];
        z_d      = (flag_src == 8'h00);
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_2) begin
        if (!res_n) begin
            state_q  <= S_IDLE;
            op_q     <= 4'h0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            dec_q    <= 1'b0;
            r_q      <= 8'h00;
            alu_c_q  <= 1'b0;
            alu_v_q  <= 1'b0;
            hc_q     <= 1'b0;
            result_q <= 8'h00;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            c_out_q  <= 1'b0;
            v_out_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= op;
                a_q   <= opnd_a;
                b_q   <= opnd_b;
                c_q   <= c_in;
                v_q   <= v_in;
                dec_q <= dec_d;
            end
            if (state_q == S_EXEC) begin
                r_q     <= alu_r;
                alu_c_q <= alu_c;
                alu_v_q <= alu_v;
                hc_q    <= half_carry;
            end
            if (write_out) begin
                result_q <= result_d;
                n_q      <= n_d;
                z_q      <= z_d;
                c_out_q  <= c_out_d;
                v_out_q  <= v_out_d;
            end
        end
    end

    assign result = result_q;
    assign n_out  = n_q;
    assign z_out  = z_q;
    assign c_out  = c_out_q;
    assign v_out  = v_out_q;

endmodule
